// File: rtl/exhaustive_checker.sv
// Exhaustive stimulus sweeper: drives every IN_W-bit vector to a DUT and a reference model,
// compares their outputs after a settle window and records the mismatch count and first failure.
module exhaustive_checker #(
    parameter int unsigned IN_W   = 3,
    parameter int unsigned OUT_W  = 1,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop_on_err,
    input  logic [OUT_W-1:0] dut_y,
    input  logic [OUT_W-1:0] ref_y,
    output logic [IN_W-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [IN_W-1:0]  first_err_vec,
    output logic [OUT_W-1:0] first_err_dut,
    output logic [OUT_W-1:0] first_err_ref
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_settle_cnt;
    logic             r_stop_on_err;

    logic             w_mismatch;
    logic             w_stim_last;
    logic             w_err_sat;
    logic [ERR_W-1:0] w_err_next;

    // Case-inequality so an unknown on either side is reported as a failure.
    assign w_mismatch  = (dut_y !== ref_y);
    assign w_stim_last = &stim;
    assign w_err_sat   = &err_count;
    assign w_err_next  = err_count + ERR_W'(w_mismatch && !w_err_sat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_settle_cnt    <= '0;
            r_stop_on_err   <= 1'b0;
            stim            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            first_err_dut   <= '0;
            first_err_ref   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state         <= S_APPLY;
                        r_settle_cnt    <= '0;
                        r_stop_on_err   <= stop_on_err;
                        stim            <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                        first_err_dut   <= '0;
                        first_err_ref   <= '0;
                    end
                end
                S_APPLY: begin
                    if (r_settle_cnt == CNT_W'(SETTLE - 1)) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        err_count <= w_err_next;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= stim;
                            first_err_dut   <= dut_y;
                            first_err_ref   <= ref_y;
                        end
                    end
                    // Sweep ends on the last vector or on the first failure when stopping early.
                    if (w_stim_last || (w_mismatch && r_stop_on_err)) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == '0);
                    end else begin
                        r_state      <= S_APPLY;
                        stim         <= stim + IN_W'(1);
                        r_settle_cnt <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exhaustive_checker.sv
// Scoreboard bench for exhaustive_checker: parity DUT/reference pair with selectable fault modes.
module tb_exhaustive_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop_on_err;
    logic [0:0] dut_y;
    logic [0:0] ref_y;
    logic [2:0] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] err_count;
    logic       first_err_valid;
    logic [2:0] first_err_vec;
    logic [0:0] first_err_dut;
    logic [0:0] first_err_ref;

    int unsigned mode;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        int unsigned errs;
        logic        fev;
        logic [2:0]  vec;
        logic        fdut;
        logic        fref;
        logic        chk_dut;
        int          busy_cycles;
        logic [2:0]  last_stim;
    } exp_t;

    exp_t q[$];

    exhaustive_checker #(
        .IN_W  (3),
        .OUT_W (1),
        .SETTLE(1),
        .ERR_W (2)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop_on_err    (stop_on_err),
        .dut_y          (dut_y),
        .ref_y          (ref_y),
        .stim           (stim),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_valid(first_err_valid),
        .first_err_vec  (first_err_vec),
        .first_err_dut  (first_err_dut),
        .first_err_ref  (first_err_ref)
    );

    always #5 clk = ~clk;

    // Reference is 3-input parity; the DUT copy carries the fault selected by mode.
    always_comb begin
        ref_y = ^stim;
        dut_y = ^stim;
        case (mode)
            1: if (stim == 3'd5) dut_y = 1'b1;
            2: if (stim == 3'd2 || stim == 3'd6) dut_y = ~(^stim);
            3: dut_y = ~(^stim);
            4: if (stim == 3'd4) dut_y = 1'bx;
            default: dut_y = ^stim;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int unsigned errs, input logic fev, input logic [2:0] vec,
                                input logic fdut, input logic fref, input logic chk_dut,
                                input int busy_cycles, input logic [2:0] last_stim);
        exp_t e;
        e.errs        = errs;
        e.fev         = fev;
        e.vec         = vec;
        e.fdut        = fdut;
        e.fref        = fref;
        e.chk_dut     = chk_dut;
        e.busy_cycles = busy_cycles;
        e.last_stim   = last_stim;
        return e;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_stim"}, 32'(stim), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_errcnt"}, 32'(err_count), 32'd0);
        chk({tag, "_fev"}, 32'(first_err_valid), 32'd0);
        chk({tag, "_fvec"}, 32'(first_err_vec), 32'd0);
        chk({tag, "_fdut"}, 32'(first_err_dut), 32'd0);
        chk({tag, "_fref"}, 32'(first_err_ref), 32'd0);
    endtask

    task automatic pulse_start(input logic soe);
        @(negedge clk);
        stop_on_err = soe;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        stop_on_err = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got done=0 expected done=1 within 200 cycles", tag);
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: checks the stim stepping while busy and scores each completed sweep.
    initial begin : monitor
        int   busy_cnt  = 0;
        int   last_busy = 0;
        logic prev_busy = 1'b0;
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt  = 0;
                prev_busy = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (busy) begin
                    chk("stim_step", 32'(stim), 32'(busy_cnt / 2));
                    busy_cnt++;
                end else if (prev_busy) begin
                    last_busy = busy_cnt;
                    busy_cnt  = 0;
                end
                if (done && !prev_done) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected no sweep pending");
                    end else begin
                        e = q.pop_front();
                        chk("busy_cycles", 32'(last_busy), 32'(e.busy_cycles));
                        chk("final_stim", 32'(stim), 32'(e.last_stim));
                        chk("err_count", 32'(err_count), 32'(e.errs));
                        chk("pass", 32'(pass), 32'(e.errs == 0));
                        chk("first_err_valid", 32'(first_err_valid), 32'(e.fev));
                        chk("first_err_vec", 32'(first_err_vec), 32'(e.vec));
                        chk("first_err_ref", 32'(first_err_ref), 32'(e.fref));
                        if (e.chk_dut) chk("first_err_dut", 32'(first_err_dut), 32'(e.fdut));
                    end
                end
                prev_busy = busy;
                prev_done = done;
            end
        end
    end

    initial begin : stimulus
        bit hit;
        rst         = 1'b1;
        start       = 1'b0;
        stop_on_err = 1'b0;
        mode        = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Nominal pass, with start re-asserted mid-sweep (must be ignored).
        q.push_back(mk(0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16, 3'd7));
        pulse_start(1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done("nominal");

        // Single fault at x=5: dut=1, ref=0.
        mode = 1;
        q.push_back(mk(1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 16, 3'd7));
        pulse_start(1'b0);
        wait_done("single");

        // Stop at first error: mismatch at x=2 (dut=0, ref=1).
        mode = 2;
        q.push_back(mk(1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 6, 3'd2));
        pulse_start(1'b1);
        wait_done("stop");

        // Saturation: all eight vectors mismatch, 2-bit counter tops out at 3.
        mode = 3;
        q.push_back(mk(3, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 16, 3'd7));
        pulse_start(1'b0);
        wait_done("saturate");

        // Unknown DUT output at x=4 counts as a mismatch (ref parity of 4 is 1).
        mode = 4;
        q.push_back(mk(1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 16, 3'd7));
        pulse_start(1'b0);
        wait_done("xdetect");

        // Restart from DONE: results clear on the sampling edge, then a clean sweep.
        mode = 0;
        q.push_back(mk(0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16, 3'd7));
        pulse_start(1'b0);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_stim", 32'(stim), 32'd0);
        chk("restart_errcnt", 32'(err_count), 32'd0);
        chk("restart_fev", 32'(first_err_valid), 32'd0);
        wait_done("restart");

        // Reset mid-sweep at stim=3.
        mode = 1;
        pulse_start(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (stim == 3'd3) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_stim3", 32'(hit), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_reset_busy", 32'(busy), 32'd0);

        // Recovery sweep after reset.
        mode = 0;
        q.push_back(mk(0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16, 3'd7));
        pulse_start(1'b0);
        wait_done("recover");

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
